// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//  Definitions shared by the systolic-array output path:
//   - default array geometry constants
//   - the output collector state enum
//   - a helper that returns the pointer width for a buffer depth
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int DEF_SIZE       = 8;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ROWS       = 8;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } collector_state_t;

  // A depth-1 buffer still needs a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
//  Up-counter with a run-time wrap value. Counts while count_enable is high;
//  the cycle it sits at rollover_val it raises rollover_flag and the next
//  enabled edge returns it to zero. clear has priority over counting.
// Ports:
//  clk, n_rst      clock, asynchronous active-low reset
//  clear           synchronous return to zero
//  count_enable    advance on this edge
//  rollover_val    last value before wrapping
//  count_out       current count
//  rollover_flag   count_out == rollover_val
// -----------------------------------------------------------------------------
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic                    w_at_end;

  assign w_at_end = (r_count == rollover_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      r_count <= w_at_end ? '0 : r_count + NUM_CNT_BITS'(1);
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = w_at_end;

endmodule

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
//  First-word-fall-through row buffer. The head entry is visible on rdata
//  whenever the buffer is not empty. A push while full is accepted only if a
//  pop happens on the same edge; otherwise it is discarded (the caller
//  detects the drop from full/pop). Pointers wrap modulo DEPTH, so any
//  DEPTH >= 1 works.
// Ports:
//  clk, n_rst   clock, asynchronous active-low reset
//  push, wdata  write request and data
//  pop          read request (ignored when empty)
//  rdata        head entry
//  full, empty  occupancy flags
// -----------------------------------------------------------------------------
module result_fifo
  import systolic_pkg::*;
#(
  parameter int WIDTH = 129,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

  assign w_do_pop  = pop && !empty;
  // When full, the slot under the write pointer is the head being popped
  // this same edge, so the write can safely reuse it.
  assign w_do_push = push && (!full || w_do_pop);

  // Storage carries no reset so it can map onto RAM; rdata is only
  // meaningful while !empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rptr];

endmodule

// File: rtl/output_collector.sv
// -----------------------------------------------------------------------------
// output_collector
//  Receiving end of the systolic array. After start_drain it captures the
//  skewed per-column results, deskews them into whole rows, buffers the rows
//  and hands them downstream over a valid/ready handshake.
//
//  Column j of row r arrives j cycles after column 0, so column j runs
//  through SIZE-1-j delay registers; the last column is used live. The delay
//  lines shift only in FILL and CAPTURE. CAPTURE pushes one row per cycle and
//  never waits for out_ready; a row arriving at a full buffer with no pop is
//  dropped and overflow is latched until the next accepted start_drain.
//
// Compile-time option:
//  RESULT_RELU_EN  when defined, negative column values are clamped to zero
//                  before buffering (combinational, no added latency).
//
// Ports:
//  clk          clock, rising edge
//  n_rst        asynchronous active-low reset
//  start_drain  start a capture (only honoured in IDLE)
//  array_out    skewed array results, column j at [j*DATA_W +: DATA_W]
//  out_data     deskewed row, same packing (zero while !out_valid)
//  out_valid    buffer not empty
//  out_ready    downstream accepts when out_valid & out_ready
//  out_last     out_data is row ROWS-1
//  busy         collector not in IDLE
//  drain_done   one-cycle pulse once the buffer has emptied
//  overflow     sticky row-dropped flag
// -----------------------------------------------------------------------------
module output_collector
  import systolic_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ROWS       = DEF_ROWS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start_drain,
  input  logic [SIZE*DATA_W-1:0] array_out,
  output logic [SIZE*DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   drain_done,
  output logic                   overflow
);

  localparam int ROW_W     = SIZE * DATA_W;
  localparam int ROW_CNT_W = $clog2(ROWS + 1);
  localparam int FILL_CNT_W = (SIZE > 2) ? $clog2(SIZE) : 1;
  // One counter serves both the fill phase and the row phase.
  localparam int CNT_W     = (ROW_CNT_W > FILL_CNT_W) ? ROW_CNT_W : FILL_CNT_W;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'((SIZE > 1) ? SIZE - 2 : 0);
  localparam logic [CNT_W-1:0] ROWS_LAST = CNT_W'(ROWS - 1);

  collector_state_t r_state;
  collector_state_t w_state_next;

  logic             w_start_ok;
  logic             w_shift;
  logic             w_push;
  logic             w_last_row;
  logic [ROW_W-1:0] w_row;
  logic [ROW_W:0]   w_rdata;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_limit;
  logic             w_cnt_wrap;
  logic             r_overflow;

  assign w_start_ok = start_drain && (r_state == IDLE);
  assign w_shift    = (r_state == FILL) || (r_state == CAPTURE);
  assign w_push     = (r_state == CAPTURE);
  assign w_last_row = w_push && (w_cnt == ROWS_LAST);

  // ---------------------------------------------------------------------------
  // Fill / row counter
  // ---------------------------------------------------------------------------
  assign w_cnt_limit = (r_state == FILL) ? FILL_LAST : ROWS_LAST;

  flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) u_row_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (r_state == IDLE),
    .count_enable (w_shift),
    .rollover_val (w_cnt_limit),
    .count_out    (w_cnt),
    .rollover_flag(w_cnt_wrap)
  );

  // ---------------------------------------------------------------------------
  // Deskew delay lines
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_col
    logic [DATA_W-1:0] w_col;

    if (gi < SIZE - 1) begin : g_dly
      localparam int D = SIZE - 1 - gi;
      logic [DATA_W-1:0] r_line [D];

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          for (int i = 0; i < D; i++) begin
            r_line[i] <= '0;
          end
        end else if (w_shift) begin
          r_line[0] <= array_out[gi*DATA_W +: DATA_W];
          for (int i = 1; i < D; i++) begin
            r_line[i] <= r_line[i-1];
          end
        end
      end

      assign w_col = r_line[D-1];
    end else begin : g_live
      assign w_col = array_out[gi*DATA_W +: DATA_W];
    end

`ifdef RESULT_RELU_EN
    assign w_row[gi*DATA_W +: DATA_W] = w_col[DATA_W-1] ? '0 : w_col;
`else
    assign w_row[gi*DATA_W +: DATA_W] = w_col;
`endif
  end

  // ---------------------------------------------------------------------------
  // Row buffer
  // ---------------------------------------------------------------------------
  result_fifo #(
    .WIDTH(ROW_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_result_fifo (
    .clk  (clk),
    .n_rst(n_rst),
    .push (w_push),
    .pop  (out_ready),
    .wdata({w_last_row, w_row}),
    .rdata(w_rdata),
    .full (w_full),
    .empty(w_empty)
  );

  // Full implies non-empty, so a pop is exactly out_ready here.
  assign w_drop = w_push && w_full && !out_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Head entry is masked so the outputs read zero while nothing is valid.
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_rdata[ROW_W-1:0];
  assign out_last  = !w_empty && w_rdata[ROW_W];
  assign overflow  = r_overflow;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    drain_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_drain) begin
          // With a single column there is no skew to fill.
          w_state_next = (SIZE == 1) ? CAPTURE : FILL;
        end
      end
      FILL: begin
        if (w_cnt_wrap) begin
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (w_cnt_wrap) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_empty) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        drain_done   = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule
